keypad_digit_entry: RTL and testbench

Sequential digit-capture stage directly downstream of the 9-line-to-BCD priority encoder (TTL74147 model) on the lab keypad path. Takes the encoder's active-low BCD output plus the raw active-low "0" key line, synchronizes and debounces them, and detects one press per physical key stroke. Each accepted digit is shifted into a multi-digit BCD entry register that feeds the display/compare stages.

---
 rtl/keypad_digit_entry_pkg.sv | 37 +++
 rtl/keypad_digit_entry_debounce.sv | 121 ++++++++++++
 rtl/keypad_digit_entry.sv | 96 +++++++++
 tb/tb_keypad_digit_entry.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_digit_entry_pkg.sv
// Shared types and constants for the keypad digit-entry path: FSM states,
// the decoded-key record and the encoder/key-0 decode helper.
package keypad_digit_entry_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic             pressed;
    logic [BCD_W-1:0] key;
  } kp_decode_t;

  localparam kp_decode_t NO_KEY = '{pressed: 1'b0, key: 4'd0};

  // Encoder digits 1..9 outrank the separate key-0 line; codes 10..15 are noise.
  function automatic kp_decode_t kp_decode(input logic [BCD_W-1:0] zn_s,
                                           input logic             key0_n_s);
    logic [BCD_W-1:0] code_s;
    kp_decode_t       res_s;
    code_s = ~zn_s;
    if ((code_s >= 4'd1) && (code_s <= 4'd9)) begin
      res_s = '{pressed: 1'b1, key: code_s};
    end else if ((code_s == 4'd0) && (key0_n_s == 1'b0)) begin
      res_s = '{pressed: 1'b1, key: 4'd0};
    end else begin
      res_s = NO_KEY;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/keypad_digit_entry_debounce.sv
// Two-flop synchronizer, key decode and press/release debounce FSM.
// Emits a one-cycle accept strobe together with the confirmed key.
module keypad_digit_entry_debounce
  import keypad_digit_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BCD_W-1:0] zn_i,
  input  logic             key0_n_i,
  output logic             accept_o,
  output logic [BCD_W-1:0] key_o
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [BCD_W:0]   sync1_q;
  logic [BCD_W:0]   sync2_q;
  kp_state_e        state_q;
  kp_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [BCD_W-1:0] cand_q;
  logic [BCD_W-1:0] cand_d;
  logic             accept_s;
  kp_decode_t       dec_s;

  // Synchronizers idle at the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {key0_n_i, zn_i};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    dec_s     = kp_decode(sync2_q[BCD_W-1:0], sync2_q[BCD_W]);
    cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    accept_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dec_s.pressed) begin
          cand_d  = dec_s.key;
          cnt_d   = '0;
          state_d = ST_CONFIRM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CONFIRM: begin
        if (dec_s.pressed && (dec_s.key == cand_q)) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == CNT_MAX) begin
            accept_s = 1'b1;
            state_d  = ST_HELD;
          end else begin
            state_d = ST_CONFIRM;
          end
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      // Rolling onto another key while held must not produce a second digit.
      ST_HELD: begin
        if (!dec_s.pressed) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_HELD;
        end
      end

      ST_RELEASE: begin
        if (dec_s.pressed) begin
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == CNT_MAX) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign accept_o = accept_s;
  assign key_o    = cand_q;

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad digit-entry top: debounced key strobe feeds a BCD shift register
// with digit count, sticky overflow and a synchronous clear that beats accept.
module keypad_digit_entry
  import keypad_digit_entry_pkg::*;
#(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BCD_W-1:0]        zn,
  input  logic                    key0_n,
  input  logic                    clr,
  output logic [BCD_W*DIGITS-1:0] entry,
  output logic [3:0]              digit_cnt,
  output logic                    new_digit,
  output logic [BCD_W-1:0]        key_code,
  output logic                    overflow
);

  localparam int unsigned ENTRY_W    = BCD_W * DIGITS;
  localparam logic [3:0]  DIGITS_CNT = 4'(DIGITS);

  logic                 acc_s;
  logic [BCD_W-1:0]     acc_key_s;
  logic [ENTRY_W-1:0]   entry_q;
  logic [ENTRY_W-1:0]   entry_d;
  logic [3:0]           cnt_q;
  logic [3:0]           cnt_d;
  logic [BCD_W-1:0]     code_q;
  logic [BCD_W-1:0]     code_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic                 pulse_q;
  logic                 pulse_d;

  keypad_digit_entry_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .zn_i     (zn),
    .key0_n_i (key0_n),
    .accept_o (acc_s),
    .key_o    (acc_key_s)
  );

  // The cast drops the oldest digit and also covers the single-digit case.
  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    if (clr) begin
      entry_d = '0;
      cnt_d   = 4'd0;
      code_d  = 4'd0;
      ovf_d   = 1'b0;
    end else if (acc_s) begin
      code_d = acc_key_s;
      if (cnt_q < DIGITS_CNT) begin
        entry_d = ENTRY_W'({entry_q, acc_key_s});
        cnt_d   = cnt_q + 4'd1;
        pulse_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
      cnt_q   <= 4'd0;
      code_q  <= 4'd0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
    end
  end

  assign entry     = entry_q;
  assign digit_cnt = cnt_q;
  assign new_digit = pulse_q;
  assign key_code  = code_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry: table of keystrokes, directed
// corner sequences and random strokes against a stroke-level reference model.
module tb_keypad_digit_entry;

  localparam int DIGITS = 4;
  localparam int DEB    = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [3:0]  zn     = 4'hF;
  logic        key0_n = 1'b1;
  logic        clr    = 1'b0;
  logic [15:0] entry;
  logic [3:0]  digit_cnt;
  logic        new_digit;
  logic [3:0]  key_code;
  logic        overflow;

  keypad_digit_entry #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .zn        (zn),
    .key0_n    (key0_n),
    .clr       (clr),
    .entry     (entry),
    .digit_cnt (digit_cnt),
    .new_digit (new_digit),
    .key_code  (key_code),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pulses = 0;
  int last_pulse_cyc = -1;
  always @(negedge clk) begin
    if (new_digit === 1'b1) begin
      pulses = pulses + 1;
      last_pulse_cyc = cyc;
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model: the digit register as plain arithmetic.
  longint m_entry = 0;
  int m_cnt = 0, m_code = 0, m_ovf = 0, exp_pulses = 0;

  task automatic model_accept(input int k);
    m_code = k;
    if (m_cnt < DIGITS) begin
      m_entry = (m_entry * 16 + k) % (longint'(1) << (4 * DIGITS));
      m_cnt = m_cnt + 1;
      exp_pulses = exp_pulses + 1;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic model_clear();
    m_entry = 0; m_cnt = 0; m_code = 0; m_ovf = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, ".entry"}, {16'd0, entry}, 32'(m_entry));
    check({name, ".digit_cnt"}, {28'd0, digit_cnt}, 32'(m_cnt));
    check({name, ".key_code"}, {28'd0, key_code}, 32'(m_code));
    check({name, ".overflow"}, {31'd0, overflow}, 32'(m_ovf));
    check({name, ".pulses"}, 32'(pulses), 32'(exp_pulses));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_key(input logic [3:0] z, input logic k0);
    zn = z;
    key0_n = k0;
  endtask

  task automatic stroke(input logic [3:0] z, input logic k0, input int hold, input int gap);
    set_key(z, k0);
    step(hold);
    set_key(4'hF, 1'b1);
    step(gap);
  endtask

  typedef struct {
    logic [3:0]  zn;
    logic        key0_n;
    logic [15:0] exp_entry;
    logic [3:0]  exp_cnt;
    logic [3:0]  exp_code;
    logic        exp_ovf;
    int          exp_inc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0, p0, k, len, rel;
    logic glitch;
    logic [3:0] nz;

    vecs[0] = '{~4'd1, 1'b1, 16'h0001, 4'd1, 4'd1, 1'b0, 1};
    vecs[1] = '{~4'd2, 1'b1, 16'h0012, 4'd2, 4'd2, 1'b0, 1};
    vecs[2] = '{~4'd3, 1'b1, 16'h0123, 4'd3, 4'd3, 1'b0, 1};
    vecs[3] = '{~4'd4, 1'b1, 16'h1234, 4'd4, 4'd4, 1'b0, 1};
    vecs[4] = '{~4'd5, 1'b1, 16'h1234, 4'd4, 4'd5, 1'b1, 0};

    // Reset state
    step(3);
    check("reset.entry", {16'd0, entry}, 32'd0);
    check("reset.digit_cnt", {28'd0, digit_cnt}, 32'd0);
    check("reset.key_code", {28'd0, key_code}, 32'd0);
    check("reset.overflow", {31'd0, overflow}, 32'd0);
    check("reset.new_digit", {31'd0, new_digit}, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Key 7 and press-to-pulse latency
    set_key(4'b1000, 1'b1);
    t0 = cyc;
    step(20);
    set_key(4'hF, 1'b1);
    step(20);
    model_accept(7);
    check_model("key7");
    check("key7.latency", 32'(last_pulse_cyc - t0), 32'd7);

    // Table: digits 1..5, fifth press overflows
    clr = 1'b1; step(1); clr = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      stroke(vecs[i].zn, vecs[i].key0_n, 20, 20);
      check($sformatf("tbl%0d.entry", i), {16'd0, entry}, {16'd0, vecs[i].exp_entry});
      check($sformatf("tbl%0d.cnt", i), {28'd0, digit_cnt}, {28'd0, vecs[i].exp_cnt});
      check($sformatf("tbl%0d.code", i), {28'd0, key_code}, {28'd0, vecs[i].exp_code});
      check($sformatf("tbl%0d.ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      check($sformatf("tbl%0d.pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_inc));
      model_accept(int'(~vecs[i].zn));
    end

    // Key 0 briefly, then key 9 over it: higher key wins
    clr = 1'b1; step(1); clr = 1'b0;
    model_clear();
    set_key(4'hF, 1'b0);
    step(2);
    set_key(~4'd9, 1'b0);
    step(20);
    set_key(4'hF, 1'b1);
    step(20);
    model_accept(9);
    check_model("k0_then_9");
    stroke(4'hF, 1'b0, 20, 20);
    model_accept(0);
    check_model("key0");
    stroke(~4'd12, 1'b0, 20, 20);
    check_model("code12_nokey");

    // Short glitch, then a held key with short bounce gaps
    clr = 1'b1; step(1); clr = 1'b0;
    model_clear();
    stroke(~4'd5, 1'b1, 3, 20);
    check_model("glitch3");
    stroke(~4'd5, 1'b1, 10, 2);
    stroke(~4'd5, 1'b1, 10, 2);
    stroke(~4'd5, 1'b1, 10, 20);
    model_accept(5);
    check_model("bounce");

    // clr on the accept cycle wins; held key is not re-accepted
    set_key(~4'd6, 1'b1);
    step(6);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    model_clear();
    check_model("clr_on_accept");
    step(20);
    set_key(4'hF, 1'b1);
    step(20);
    check_model("clr_no_reaccept");

    // Reset mid-hold: key must re-debounce from scratch
    set_key(~4'd3, 1'b1);
    step(20);
    model_accept(3);
    check_model("pre_reset");
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    t0 = cyc;
    model_clear();
    check_model("mid_hold_reset");
    step(15);
    model_accept(3);
    check_model("reaccept");
    check("reaccept.latency", 32'(last_pulse_cyc - t0), 32'd7);
    set_key(4'hF, 1'b1);
    step(20);

    // Random strokes against the stroke-level model
    for (int s = 0; s < 60; s++) begin
      k = $urandom_range(0, 9);
      glitch = ($urandom_range(0, 3) == 0);
      len = glitch ? $urandom_range(1, DEB - 1) : $urandom_range(DEB + 3, DEB + 12);
      set_key(~4'(k), (k == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      step(len);
      if (!glitch && ($urandom_range(0, 1) == 1)) begin
        nz = ~4'($urandom_range(0, 9));
        set_key(nz, 1'($urandom_range(0, 1)));
        step($urandom_range(1, 10));
      end
      if ($urandom_range(0, 1) == 1) begin
        set_key(4'hF, 1'b1);
      end else begin
        set_key(~4'($urandom_range(10, 15)), 1'($urandom_range(0, 1)));
      end
      if (!glitch) model_accept(k);
      rel = $urandom_range(DEB + 3, DEB + 10);
      step(rel);
      check_model($sformatf("rnd%0d", s));
      if ($urandom_range(0, 7) == 0) begin
        clr = 1'b1; step(1); clr = 1'b0;
        model_clear();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
